// File: rtl/onchip_mem_pattern_master.sv
// ---------------------------------------------------------------------------
// onchip_mem_pattern_master
//
// Avalon-MM master that self-tests a single-port on-chip RAM. On start it
// writes the pattern (seed + i) to addresses (base_addr + i) for
// i = 0..N-1. It then reads the same window back and compares each word
// against the pattern. It reports pass/fail, a saturating mismatch count and
// the address of the first mismatch.
//
// Ports
//   clk, reset      system clock, asynchronous active-high reset
//   start           1-cycle request, accepted only when idle
//   base_addr       first word address of the test window
//   word_count      number of words (0 .. 2^ADDR_W)
//   seed            pattern value for word 0
//   busy            high while a run is in progress (WRITE/READ/DRAIN)
//   done            1-cycle completion pulse
//   pass            err_count == 0, valid from done until the next start
//   err_count       saturating mismatch count
//   first_err_addr  address of the first mismatching word (0 if none)
//   address, byteenable, chipselect, write, writedata
//                   Avalon-MM master request signals
//   clken           RAM clock enable, low only while reset is asserted
//   readdata        Avalon read data, valid READ_LATENCY cycles after issue
// ---------------------------------------------------------------------------
module onchip_mem_pattern_master #(
    parameter int ADDR_W       = 11,
    parameter int DATA_W       = 32,
    parameter int READ_LATENCY = 1,
    parameter int ERRCNT_W     = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [ADDR_W-1:0]   base_addr,
    input  logic [ADDR_W:0]     word_count,
    input  logic [DATA_W-1:0]   seed,
    output logic                busy,
    output logic                done,
    output logic                pass,
    output logic [ERRCNT_W-1:0] err_count,
    output logic [ADDR_W-1:0]   first_err_addr,
    output logic [ADDR_W-1:0]   address,
    output logic [DATA_W/8-1:0] byteenable,
    output logic                chipselect,
    output logic                write,
    output logic [DATA_W-1:0]   writedata,
    output logic                clken,
    input  logic [DATA_W-1:0]   readdata
);

    localparam int CNT_W   = ADDR_W + 1;
    localparam int DRAIN_W = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
    localparam logic [DRAIN_W-1:0] DRAIN_INIT = DRAIN_W'(READ_LATENCY - 1);
    localparam logic [CNT_W-1:0]   CNT_ONE    = CNT_W'(1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE,
        S_READ,
        S_DRAIN,
        S_DONE
    } state_t;

    // Control and result registers
    state_t                state_q, state_d;
    logic [ADDR_W-1:0]     base_q, base_d;
    logic [CNT_W-1:0]      count_q, count_d;       // latched word_count
    logic [DATA_W-1:0]     seed_q, seed_d;
    logic [CNT_W-1:0]      remain_q, remain_d;     // accesses left in this phase
    logic [DRAIN_W-1:0]    drain_q, drain_d;
    logic [ADDR_W-1:0]     address_q, address_d;
    logic [DATA_W-1:0]     pat_q, pat_d;           // pattern word for current access
    logic                  chipselect_q, chipselect_d;
    logic                  write_q, write_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  pass_q, pass_d;
    logic [ERRCNT_W-1:0]   err_count_q, err_count_d;
    logic [ADDR_W-1:0]     first_err_addr_q, first_err_addr_d;

    // Read-compare pipeline: stage k holds the read issued k+1 cycles ago,
    // so the last stage lines up with readdata.
    logic [READ_LATENCY-1:0] pipe_vld_q, pipe_vld_d;
    logic [DATA_W-1:0]       pipe_data_q [READ_LATENCY];
    logic [DATA_W-1:0]       pipe_data_d [READ_LATENCY];
    logic [ADDR_W-1:0]       pipe_addr_q [READ_LATENCY];
    logic [ADDR_W-1:0]       pipe_addr_d [READ_LATENCY];

    logic mismatch;

    always_comb begin
        // NOTE: every signal gets a default first so no path through the case leaves it unassigned (no latches).
        state_d          = state_q;
        base_d           = base_q;
        count_d          = count_q;
        seed_d           = seed_q;
        remain_d         = remain_q;
        drain_d          = drain_q;
        address_d        = address_q;
        pat_d            = pat_q;
        chipselect_d     = chipselect_q;
        write_d          = write_q;
        busy_d           = busy_q;
        done_d           = 1'b0;
        pass_d           = pass_q;
        err_count_d      = err_count_q;
        first_err_addr_d = first_err_addr_q;

        // Shift the compare pipeline every cycle; a stage is valid only for reads.
        pipe_vld_d[0]  = chipselect_q & ~write_q;
        pipe_data_d[0] = pat_q;
        pipe_addr_d[0] = address_q;
        for (int k = 1; k < READ_LATENCY; k++) begin
            pipe_vld_d[k]  = pipe_vld_q[k-1];
            pipe_data_d[k] = pipe_data_q[k-1];
            pipe_addr_d[k] = pipe_addr_q[k-1];
        end

        // Retire the oldest read. err_count never returns to zero once it
        // has counted, so zero marks "no mismatch seen yet".
        mismatch = pipe_vld_q[READ_LATENCY-1] &&
                   (readdata != pipe_data_q[READ_LATENCY-1]);
        if (mismatch) begin
            if (err_count_q != {ERRCNT_W{1'b1}}) begin
                err_count_d = err_count_q + ERRCNT_W'(1);
            end
            if (err_count_q == '0) begin
                first_err_addr_d = pipe_addr_q[READ_LATENCY-1];
            end
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    base_d           = base_addr;
                    count_d          = word_count;
                    seed_d           = seed;
                    err_count_d      = '0;
                    first_err_addr_d = '0;
                    pass_d           = 1'b0;
                    if (word_count == '0) begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                        pass_d  = 1'b1;
                    end else begin
                        state_d      = S_WRITE;
                        busy_d       = 1'b1;
                        chipselect_d = 1'b1;
                        write_d      = 1'b1;
                        address_d    = base_addr;
                        pat_d        = seed;
                        remain_d     = word_count;
                    end
                end
            end

            S_WRITE: begin
                if (remain_q == CNT_ONE) begin
                    // Last write issued; restart the window for reads.
                    state_d   = S_READ;
                    write_d   = 1'b0;
                    address_d = base_q;
                    pat_d     = seed_q;
                    remain_d  = count_q;
                end else begin
                    address_d = address_q + ADDR_W'(1);
                    pat_d     = pat_q + DATA_W'(1);
                    remain_d  = remain_q - CNT_ONE;
                end
            end

            S_READ: begin
                if (remain_q == CNT_ONE) begin
                    state_d      = S_DRAIN;
                    chipselect_d = 1'b0;
                    address_d    = '0;
                    pat_d        = '0;
                    drain_d      = DRAIN_INIT;
                end else begin
                    address_d = address_q + ADDR_W'(1);
                    pat_d     = pat_q + DATA_W'(1);
                    remain_d  = remain_q - CNT_ONE;
                end
            end

            S_DRAIN: begin
                if (drain_q == '0) begin
                    // The last compare retires on this edge, so use err_count_d.
                    state_d = S_DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    pass_d  = (err_count_d == '0);
                end else begin
                    drain_d = drain_q - DRAIN_W'(1);
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q          <= S_IDLE;
            base_q           <= '0;
            count_q          <= '0;
            seed_q           <= '0;
            remain_q         <= '0;
            drain_q          <= '0;
            address_q        <= '0;
            pat_q            <= '0;
            chipselect_q     <= 1'b0;
            write_q          <= 1'b0;
            busy_q           <= 1'b0;
            done_q           <= 1'b0;
            pass_q           <= 1'b0;
            err_count_q      <= '0;
            first_err_addr_q <= '0;
            pipe_vld_q       <= '0;
        end else begin
            state_q          <= state_d;
            base_q           <= base_d;
            count_q          <= count_d;
            seed_q           <= seed_d;
            remain_q         <= remain_d;
            drain_q          <= drain_d;
            address_q        <= address_d;
            pat_q            <= pat_d;
            chipselect_q     <= chipselect_d;
            write_q          <= write_d;
            busy_q           <= busy_d;
            done_q           <= done_d;
            pass_q           <= pass_d;
            err_count_q      <= err_count_d;
            first_err_addr_q <= first_err_addr_d;
            pipe_vld_q       <= pipe_vld_d;
        end
    end

    // NOTE: pipeline payload has no reset; it is qualified by pipe_vld_q, which is reset.
    always_ff @(posedge clk) begin
        pipe_data_q <= pipe_data_d;
        pipe_addr_q <= pipe_addr_d;
    end

    assign busy           = busy_q;
    assign done           = done_q;
    assign pass           = pass_q;
    assign err_count      = err_count_q;
    assign first_err_addr = first_err_addr_q;
    assign address        = address_q;
    assign chipselect     = chipselect_q;
    assign write          = write_q;
    assign writedata      = pat_q;
    assign byteenable     = {(DATA_W/8){chipselect_q}};
    assign clken          = ~reset;

endmodule
